// File: rtl/apb_i2c_master_pkg.sv
// Shared definitions for the APB-controlled I2C master: register offsets,
// CMD bit positions and the bus engine state encoding.
package apb_i2c_master_pkg;

    localparam logic [3:0] REG_STATUS = 4'h0;
    localparam logic [3:0] REG_CMD    = 4'h2;
    localparam logic [3:0] REG_DATA   = 4'h4;
    localparam logic [3:0] REG_RXDATA = 4'h6;

    localparam int CMD_GO      = 7;
    localparam int CMD_CLR     = 6;
    localparam int CMD_STOP_EN = 5;
    localparam int CMD_ACK_CHK = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_AACK,
        ST_DATA,
        ST_DACK,
        ST_STOP
    } i2c_state_e;

endpackage

// File: rtl/i2c_master_engine.sv
// Single-master I2C frame engine: START, address byte, one data byte
// (write or read) and optional STOP, timed in SCL quarter periods.
module i2c_master_engine
    import apb_i2c_master_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_launch,
    input  logic [15:0] i_frame,
    input  logic        i_stop_en,
    input  logic        i_ack_chk,
    input  logic        i_sda,
    output logic        o_scl,
    output logic        o_sda_oe,
    output i2c_state_e  o_state,
    output logic        o_done,
    output logic        o_nack,
    output logic [7:0]  o_rx_data
);

    i2c_state_e  r_state;
    logic [15:0] r_qcnt;
    logic [1:0]  r_q;
    logic [2:0]  r_bit;
    logic [7:0]  r_addr;
    logic [7:0]  r_data;
    logic [7:0]  r_rx_shift;
    logic [7:0]  r_rx_data;
    logic        r_stop_en;
    logic        r_ack_chk;
    logic        r_sample;
    logic        r_scl;
    logic        r_sda_oe;
    logic        r_done;
    logic        r_nack;
    logic        w_tick;
    logic        w_read;
    logic        w_dnack;

    assign w_tick  = (r_qcnt == 16'(CLK_DIV - 1));
    assign w_read  = r_addr[0];
    // In a read the master answers the data byte itself, so its ACK slot never flags.
    assign w_dnack = r_sample & ~w_read;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_qcnt     <= '0;
            r_q        <= '0;
            r_bit      <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_stop_en  <= 1'b0;
            r_ack_chk  <= 1'b0;
            r_sample   <= 1'b0;
            r_scl      <= 1'b1;
            r_sda_oe   <= 1'b0;
            r_done     <= 1'b0;
            r_nack     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_nack <= 1'b0;
            if (r_state == ST_IDLE) begin
                r_qcnt <= '0;
                r_q    <= '0;
                if (i_launch) begin
                    r_state   <= ST_START;
                    r_addr    <= i_frame[15:8];
                    r_data    <= i_frame[7:0];
                    r_stop_en <= i_stop_en;
                    r_ack_chk <= i_ack_chk;
                    r_sda_oe  <= 1'b0;
                end
            end else if (!w_tick) begin
                r_qcnt <= r_qcnt + 16'd1;
            end else begin
                r_qcnt <= '0;
                r_q    <= r_q + 2'd1;
                // Each case arm sets the bus for the quarter being entered.
                case (r_q)
                    2'd0: r_scl <= 1'b1;
                    2'd1: begin
                        if (r_state == ST_START) begin
                            r_sda_oe <= 1'b1;
                        end else if (r_state == ST_STOP) begin
                            r_sda_oe <= 1'b0;
                        end else begin
                            r_sample <= i_sda;
                            if (r_state == ST_DATA && w_read) begin
                                r_rx_shift <= {r_rx_shift[6:0], i_sda};
                            end
                        end
                    end
                    2'd2: begin
                        if (r_state != ST_STOP) begin
                            r_scl <= 1'b0;
                        end
                    end
                    default: begin
                        case (r_state)
                            ST_START: begin
                                r_state  <= ST_ADDR;
                                r_bit    <= 3'd7;
                                r_sda_oe <= ~r_addr[7];
                            end
                            ST_ADDR: begin
                                if (r_bit == 3'd0) begin
                                    r_state  <= ST_AACK;
                                    r_sda_oe <= 1'b0;
                                end else begin
                                    r_bit    <= r_bit - 3'd1;
                                    r_sda_oe <= ~r_addr[r_bit - 3'd1];
                                end
                            end
                            ST_AACK: begin
                                r_nack <= r_sample;
                                if (r_sample && r_ack_chk) begin
                                    r_state  <= ST_STOP;
                                    r_sda_oe <= 1'b1;
                                end else begin
                                    r_state  <= ST_DATA;
                                    r_bit    <= 3'd7;
                                    r_sda_oe <= ~w_read & ~r_data[7];
                                end
                            end
                            ST_DATA: begin
                                if (r_bit == 3'd0) begin
                                    r_state  <= ST_DACK;
                                    r_sda_oe <= 1'b0;
                                    if (w_read) begin
                                        r_rx_data <= r_rx_shift;
                                    end
                                end else begin
                                    r_bit    <= r_bit - 3'd1;
                                    r_sda_oe <= ~w_read & ~r_data[r_bit - 3'd1];
                                end
                            end
                            ST_DACK: begin
                                r_nack <= w_dnack;
                                if (r_stop_en || (w_dnack && r_ack_chk)) begin
                                    r_state  <= ST_STOP;
                                    r_sda_oe <= 1'b1;
                                end else begin
                                    // No STOP: park with SCL low, SDA released, ready for a repeated START.
                                    r_state  <= ST_IDLE;
                                    r_sda_oe <= 1'b0;
                                    r_done   <= 1'b1;
                                end
                            end
                            default: begin
                                r_state <= ST_IDLE;
                                r_done  <= 1'b1;
                            end
                        endcase
                    end
                endcase
            end
        end
    end

    assign o_scl     = r_scl;
    assign o_sda_oe  = r_sda_oe;
    assign o_state   = r_state;
    assign o_done    = r_done;
    assign o_nack    = r_nack;
    assign o_rx_data = r_rx_data;

endmodule

// File: rtl/apb_i2c_master.sv
// Zero-wait APB3 register file (STATUS/CMD/DATA/RXDATA) in front of the
// I2C frame engine; SDA is open-drain, SCL push-pull.
module apb_i2c_master
    import apb_i2c_master_pkg::*;
#(
    parameter int ADDRESSWIDTH = 4,
    parameter int DATAWIDTH    = 32,
    parameter int CLK_DIV      = 4
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic [ADDRESSWIDTH-1:0] PADDR,
    input  logic [DATAWIDTH-1:0]    PWDATA,
    input  logic                    PWRITE,
    input  logic                    PSELx,
    input  logic                    PENABLE,
    output logic [DATAWIDTH-1:0]    PRDATA,
    output logic                    PREADY,
    input  logic                    i2c_enable,
    output logic                    i2c_scl,
    inout  wire                     i2c_sda
);

    logic [15:0]          r_data;
    logic                 r_stop_en;
    logic                 r_ack_chk;
    logic                 r_pending;
    logic                 r_done;
    logic                 r_nack;
    logic [DATAWIDTH-1:0] r_prdata;
    logic [15:0]          w_rd_val;
    logic                 w_wr;
    logic                 w_rd_setup;
    logic                 w_launch;
    logic                 w_busy;
    logic                 w_sda_oe;
    logic                 w_eng_done;
    logic                 w_eng_nack;
    logic [7:0]           w_rx_data;
    i2c_state_e           w_state;
    logic                 w_unused_wdata;

    assign w_wr           = PSELx & PENABLE & PWRITE;
    assign w_rd_setup     = PSELx & ~PENABLE & ~PWRITE;
    assign w_busy         = (w_state != ST_IDLE);
    assign w_launch       = ~w_busy & r_pending & i2c_enable;
    assign w_unused_wdata = ^PWDATA[DATAWIDTH-1:16];

    always_comb begin
        w_rd_val = '0;
        if (PADDR == ADDRESSWIDTH'(REG_STATUS)) begin
            w_rd_val = {12'd0, r_pending, r_nack, r_done, w_busy};
        end else if (PADDR == ADDRESSWIDTH'(REG_CMD)) begin
            w_rd_val = {10'd0, r_stop_en, r_ack_chk, 4'd0};
        end else if (PADDR == ADDRESSWIDTH'(REG_DATA)) begin
            w_rd_val = r_data;
        end else if (PADDR == ADDRESSWIDTH'(REG_RXDATA)) begin
            w_rd_val = {8'd0, w_rx_data};
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_data    <= '0;
            r_stop_en <= 1'b0;
            r_ack_chk <= 1'b0;
            r_pending <= 1'b0;
            r_done    <= 1'b0;
            r_nack    <= 1'b0;
            r_prdata  <= '0;
        end else begin
            if (w_launch) begin
                r_pending <= 1'b0;
            end
            // A GO arriving on the launch edge queues the next frame.
            if (w_wr && PADDR == ADDRESSWIDTH'(REG_CMD)) begin
                r_stop_en <= PWDATA[CMD_STOP_EN];
                r_ack_chk <= PWDATA[CMD_ACK_CHK];
                if (PWDATA[CMD_GO]) begin
                    r_pending <= 1'b1;
                end
                if (PWDATA[CMD_CLR]) begin
                    r_done <= 1'b0;
                    r_nack <= 1'b0;
                end
            end
            if (w_wr && PADDR == ADDRESSWIDTH'(REG_DATA)) begin
                r_data <= PWDATA[15:0];
            end
            if (w_eng_done) begin
                r_done <= 1'b1;
            end
            if (w_eng_nack) begin
                r_nack <= 1'b1;
            end
            if (w_rd_setup) begin
                r_prdata <= DATAWIDTH'(w_rd_val);
            end
        end
    end

    i2c_master_engine #(
        .CLK_DIV (CLK_DIV)
    ) u_engine (
        .i_clk     (PCLK),
        .i_rst_n   (PRESETn),
        .i_launch  (w_launch),
        .i_frame   (r_data),
        .i_stop_en (r_stop_en),
        .i_ack_chk (r_ack_chk),
        .i_sda     (i2c_sda),
        .o_scl     (i2c_scl),
        .o_sda_oe  (w_sda_oe),
        .o_state   (w_state),
        .o_done    (w_eng_done),
        .o_nack    (w_eng_nack),
        .o_rx_data (w_rx_data)
    );

    assign i2c_sda = w_sda_oe ? 1'b0 : 1'bz;
    assign PRDATA  = r_prdata;
    assign PREADY  = 1'b1;

endmodule

// File: tb/tb_apb_i2c_master.sv
// Directed bench for apb_i2c_master: APB driver tasks, an I2C bus monitor
// with an ACKing/data-driving slave, and hand-computed bus event streams.
module tb_apb_i2c_master;

    localparam logic [3:0] A_STATUS = 4'h0;
    localparam logic [3:0] A_CMD    = 4'h2;
    localparam logic [3:0] A_DATA   = 4'h4;
    localparam logic [3:0] A_RXDATA = 4'h6;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic [3:0]  PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic        PWRITE = 1'b0;
    logic        PSELx = 1'b0;
    logic        PENABLE = 1'b0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        i2c_enable = 1'b0;
    logic        i2c_scl;
    wire         sda_bus;

    int n_total = 0;
    int n_bad = 0;

    // Bus monitor / slave state. Event codes: 0/1 data bit, 2 START, 3 STOP.
    logic         slave_low;
    logic         slave_nack = 1'b0;
    logic [7:0]   slave_byte = 8'h00;
    logic         prev_scl, prev_sda, pend, pend_val;
    logic [7:0]   addr_rx;
    int           bitcnt;
    logic [127:0] ev_log = '0;
    int           ev_n = 0;
    int           mon_cyc = 0;
    int           last_rise = 0;
    int           mon_period = 0;

    logic [127:0] exp_v;
    int           exp_n;

    pullup (sda_bus);
    assign sda_bus = slave_low ? 1'b0 : 1'bz;

    apb_i2c_master #(
        .ADDRESSWIDTH (4),
        .DATAWIDTH    (32),
        .CLK_DIV      (4)
    ) dut (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PWRITE     (PWRITE),
        .PSELx      (PSELx),
        .PENABLE    (PENABLE),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .i2c_enable (i2c_enable),
        .i2c_scl    (i2c_scl),
        .i2c_sda    (sda_bus)
    );

    always #5 PCLK = ~PCLK;

    always @(negedge PCLK) begin
        mon_cyc  <= mon_cyc + 1;
        prev_scl <= i2c_scl;
        prev_sda <= sda_bus;
        if (!PRESETn) begin
            pend      <= 1'b0;
            pend_val  <= 1'b0;
            bitcnt    <= 0;
            addr_rx   <= '0;
            slave_low <= 1'b0;
        end else if (prev_scl && i2c_scl && prev_sda && !sda_bus) begin
            ev_log <= {ev_log[125:0], 2'd2};
            ev_n   <= ev_n + 1;
            pend   <= 1'b0;
            bitcnt <= 0;
        end else if (prev_scl && i2c_scl && !prev_sda && sda_bus) begin
            ev_log <= {ev_log[125:0], 2'd3};
            ev_n   <= ev_n + 1;
            pend   <= 1'b0;
        end else if (!prev_scl && i2c_scl) begin
            pend       <= 1'b1;
            pend_val   <= sda_bus;
            mon_period <= mon_cyc - last_rise;
            last_rise  <= mon_cyc;
        end else if (prev_scl && !i2c_scl && pend) begin
            ev_log <= {ev_log[125:0], 1'b0, pend_val};
            ev_n   <= ev_n + 1;
            pend   <= 1'b0;
            bitcnt <= bitcnt + 1;
            if (bitcnt < 8) addr_rx <= {addr_rx[6:0], pend_val};
            if (bitcnt == 7) slave_low <= !slave_nack;
            else if (bitcnt >= 8 && bitcnt <= 15) slave_low <= addr_rx[0] ? !slave_byte[15 - bitcnt] : 1'b0;
            else if (bitcnt == 16) slave_low <= !addr_rx[0];
            else slave_low <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge PCLK);
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        @(negedge PCLK);
        PENABLE = 1'b1;
        @(negedge PCLK);
        PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge PCLK);
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        @(negedge PCLK);
        PENABLE = 1'b1;
        d = PRDATA;
        @(negedge PCLK);
        PSELx = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic chk_reg(input string tag, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] d;
        apb_read(a, d);
        chk(tag, d, exp);
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] s;
        int k;
        for (k = 0; k < 1000; k++) begin
            apb_read(A_STATUS, s);
            if ((s & 32'h9) == 0) break;
        end
        chk({tag, "_idle"}, k < 1000, 1'b1);
    endtask

    task automatic exp_clear();
        exp_v = '0;
        exp_n = 0;
    endtask

    task automatic exp_push(input logic [1:0] c);
        exp_v = {exp_v[125:0], c};
        exp_n++;
    endtask

    task automatic exp_frame(input logic [7:0] a, input logic aack, input logic has_data,
                             input logic [7:0] d, input logic dack);
        exp_push(2'd2);
        for (int i = 7; i >= 0; i--) exp_push({1'b0, a[i]});
        exp_push({1'b0, aack});
        if (has_data) begin
            for (int i = 7; i >= 0; i--) exp_push({1'b0, d[i]});
            exp_push({1'b0, dack});
        end
        exp_push(2'd3);
    endtask

    task automatic chk_bus(input string tag, input int base);
        int cnt;
        logic [127:0] mask;
        cnt = ev_n - base;
        chk({tag, "_events"}, cnt, exp_n);
        mask = (cnt >= 64) ? '1 : ((128'd1 << (2 * cnt)) - 128'd1);
        chk({tag, "_bus"}, ev_log & mask, exp_v);
    endtask

    initial begin
        int base;
        logic [31:0] d;

        repeat (4) @(negedge PCLK);
        chk("rst_prdata", PRDATA, 32'h0);
        chk("rst_pready", PREADY, 1'b1);
        chk("rst_scl", i2c_scl, 1'b1);
        chk("rst_sda", sda_bus, 1'b1);
        PRESETn = 1'b1;
        chk_reg("rst_status", A_STATUS, 32'h0);
        chk_reg("rst_cmd", A_CMD, 32'h0);
        chk_reg("rst_data", A_DATA, 32'h0);
        chk_reg("rst_rxdata", A_RXDATA, 32'h0);

        // Register access, setup-only cycle, unmapped address
        apb_write(A_DATA, 32'h0000_54AA);
        apb_write(A_CMD, 32'h0000_0020);
        chk_reg("rd_data", A_DATA, 32'h54AA);
        chk_reg("rd_cmd", A_CMD, 32'h20);
        @(negedge PCLK);
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = A_DATA; PWDATA = 32'h1234;
        @(negedge PCLK);
        PSELx = 1'b0; PWRITE = 1'b0;
        chk_reg("setup_only", A_DATA, 32'h54AA);
        apb_write(4'h8, 32'hFFFF);
        chk_reg("unmapped", 4'h8, 32'h0);
        chk_reg("no_go_status", A_STATUS, 32'h0);

        // Write frame with STOP
        exp_clear();
        exp_frame(8'h54, 1'b0, 1'b1, 8'hAA, 1'b0);
        base = ev_n;
        apb_write(A_CMD, 32'hF0);
        i2c_enable = 1'b1;
        wait_idle("wr");
        chk_bus("wr", base);
        chk_reg("wr_status", A_STATUS, 32'h2);
        chk_reg("wr_cmd", A_CMD, 32'h30);
        chk("scl_period", mon_period, 16);
        chk("wr_scl_idle", i2c_scl, 1'b1);

        // Pending gating by i2c_enable
        i2c_enable = 1'b0;
        apb_write(A_CMD, 32'h40);
        base = ev_n;
        apb_write(A_CMD, 32'hF0);
        repeat (40) @(negedge PCLK);
        chk_reg("pend_status", A_STATUS, 32'h8);
        chk("pend_scl", i2c_scl, 1'b1);
        chk("pend_sda", sda_bus, 1'b1);
        chk("pend_no_events", ev_n - base, 0);
        @(negedge PCLK);
        i2c_enable = 1'b1;
        chk_reg("launch_status", A_STATUS, 32'h1);
        repeat (100) @(negedge PCLK);
        i2c_enable = 1'b0;
        wait_idle("pend");
        chk_bus("pend", base);
        chk_reg("pend_done", A_STATUS, 32'h2);
        i2c_enable = 1'b1;

        // Address NACK with ACK_CHK
        slave_nack = 1'b1;
        exp_clear();
        exp_frame(8'h54, 1'b1, 1'b0, 8'h00, 1'b0);
        base = ev_n;
        apb_write(A_CMD, 32'hF0);
        wait_idle("nack");
        chk_bus("nack", base);
        chk_reg("nack_status", A_STATUS, 32'h6);
        apb_write(A_CMD, 32'h40);
        chk_reg("clr_status", A_STATUS, 32'h0);
        slave_nack = 1'b0;

        // Back-to-back: GO while busy, new DATA must not touch frame in flight
        exp_clear();
        exp_frame(8'h54, 1'b0, 1'b1, 8'hAA, 1'b0);
        exp_frame(8'hF0, 1'b0, 1'b1, 8'hAA, 1'b0);
        base = ev_n;
        apb_write(A_CMD, 32'hF0);
        repeat (20) @(negedge PCLK);
        apb_write(A_DATA, 32'hF0AA);
        apb_write(A_CMD, 32'hF0);
        chk_reg("b2b_status", A_STATUS, 32'h9);
        wait_idle("b2b");
        chk_bus("b2b", base);
        chk_reg("b2b_done", A_STATUS, 32'h2);

        // Read frame: slave returns 0x3C, master NACKs the byte
        slave_byte = 8'h3C;
        apb_write(A_DATA, 32'hA100);
        exp_clear();
        exp_frame(8'hA1, 1'b0, 1'b1, 8'h3C, 1'b1);
        base = ev_n;
        apb_write(A_CMD, 32'hF0);
        wait_idle("rd");
        chk_bus("rd", base);
        chk_reg("rd_rxdata", A_RXDATA, 32'h3C);
        chk_reg("rd_status", A_STATUS, 32'h2);

        // Reset in the middle of a frame
        apb_write(A_DATA, 32'h54AA);
        apb_write(A_CMD, 32'hF0);
        repeat (60) @(negedge PCLK);
        PRESETn = 1'b0;
        @(negedge PCLK);
        #1;
        chk("midrst_scl", i2c_scl, 1'b1);
        chk("midrst_sda", sda_bus, 1'b1);
        @(negedge PCLK);
        PRESETn = 1'b1;
        chk_reg("midrst_status", A_STATUS, 32'h0);
        chk_reg("midrst_data", A_DATA, 32'h0);
        chk_reg("midrst_rxdata", A_RXDATA, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
